// File: rtl/pwm_deadtime_driver.sv
// Fixed-period PWM with period-boundary duty shadowing and a complementary
// high/low-side output pair separated by a programmable dead time.
//
// state | meaning
// IDLE  | disabled or in reset, both outputs low
// DEAD  | dead-time countdown toward tgt, both outputs low
// HIGH  | high-side driven (PWM_Out)
// LOW   | low-side driven (PWM_Out_N)
module pwm_deadtime_driver #(
    parameter int WIDTH     = 6,
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Duty_Input,
    output logic             PWM_Out,
    output logic             PWM_Out_N,
    output logic             Period_Start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [3:0]       DT      = 4'(DEAD_TIME);

    typedef enum logic [1:0] {IDLE, DEAD, HIGH, LOW} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    pre_cnt, pre_cnt_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] duty_shadow, duty_shadow_nxt;
    logic             tgt, tgt_nxt;
    logic [3:0]       dcnt, dcnt_nxt;
    logic             period_start, period_start_nxt;
    logic             raw, tick;

    assign raw  = (cnt < duty_shadow);
    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state        <= IDLE;
            pre_cnt      <= '0;
            cnt          <= '0;
            duty_shadow  <= '0;
            tgt          <= 1'b0;
            dcnt         <= DT;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            pre_cnt      <= pre_cnt_nxt;
            cnt          <= cnt_nxt;
            duty_shadow  <= duty_shadow_nxt;
            tgt          <= tgt_nxt;
            dcnt         <= dcnt_nxt;
            period_start <= period_start_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pre_cnt_nxt      = pre_cnt;
        cnt_nxt          = cnt;
        duty_shadow_nxt  = duty_shadow;
        tgt_nxt          = tgt;
        dcnt_nxt         = dcnt;
        period_start_nxt = 1'b0;

        if (!Enable) begin
            state_nxt       = IDLE;
            pre_cnt_nxt     = '0;
            cnt_nxt         = '0;
            duty_shadow_nxt = '0;
            tgt_nxt         = 1'b0;
            dcnt_nxt        = DT;
        end else begin
            if (state == IDLE) begin
                pre_cnt_nxt      = '0;
                cnt_nxt          = '0;
                duty_shadow_nxt  = Duty_Input;
                period_start_nxt = 1'b1;
            end else if (tick) begin
                pre_cnt_nxt = '0;
                if (cnt == CNT_MAX) begin
                    cnt_nxt          = '0;
                    duty_shadow_nxt  = Duty_Input;
                    period_start_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                pre_cnt_nxt = pre_cnt + 1'b1;
            end

            // A raw change always restarts the dead interval, even mid-countdown.
            if (raw != tgt) begin
                tgt_nxt = raw;
                if (DEAD_TIME == 0) begin
                    dcnt_nxt  = 4'd0;
                    state_nxt = raw ? HIGH : LOW;
                end else begin
                    dcnt_nxt  = DT;
                    state_nxt = DEAD;
                end
            end else if (dcnt > 4'd1) begin
                dcnt_nxt  = dcnt - 4'd1;
                state_nxt = DEAD;
            end else begin
                dcnt_nxt  = 4'd0;
                state_nxt = tgt ? HIGH : LOW;
            end
        end
    end

    assign PWM_Out      = (state == HIGH);
    assign PWM_Out_N    = (state == LOW);
    assign Period_Start = period_start;

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Downstream consumer of the sawtooth/sine generator's 6-bit `Duty_Output`.
- Turns each duty word into a fixed-period PWM waveform, latching the duty only at period boundaries so there are no mid-period glitches.
- Drives a complementary high-side/low-side pair with a programmable dead time.
- Emits a one-cycle `Period_Start` strobe that the upstream generator uses to advance its waveform step.

Parameters:
- WIDTH, 6: width of the duty word and the period counter. Period = 2^WIDTH counts.
- PRESCALE, 1: sysclk cycles per PWM count (>=1). Period = 2^WIDTH*PRESCALE sysclk cycles.
- DEAD_TIME, 2: sysclk cycles both outputs are held low between complementary transitions (0..15).

Ports:
- sysclk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- Enable, input, 1: run/stop. When low, the block idles with both outputs low.
- Duty_Input, input, WIDTH: duty word, connected to the upstream `Duty_Output`.
- PWM_Out, output, 1: high-side drive.
- PWM_Out_N, output, 1: low-side drive, complementary to `PWM_Out` with dead time inserted.
- Period_Start, output, 1: one-sysclk pulse on the first cycle of each PWM period.

Behaviour:
- One clock: sysclk. Reset is synchronous and active-high.
- Reset, or Enable low (same effect):
  - pre_cnt=0, cnt=0, duty_shadow=0, tgt=0, dcnt=DEAD_TIME.
  - PWM_Out=0, PWM_Out_N=0, Period_Start=0.
  - Reset overrides Enable.
  - Reset or Enable drop mid-period takes effect on the next edge; no period completion.
- Start:
  - On the first edge with Enable=1 after idle: cnt<=0, pre_cnt<=0, duty_shadow<=Duty_Input, Period_Start<=1.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1.
  - tick is asserted when pre_cnt==PRESCALE-1; pre_cnt then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Period counter:
  - On tick, cnt increments modulo 2^WIDTH.
  - On the edge where tick && cnt==2^WIDTH-1: cnt<=0, duty_shadow<=Duty_Input, Period_Start<=1.
  - Period_Start is 0 on all other edges.
  - Duty_Input is sampled only on that edge; changes at other times are ignored.
- Raw compare:
  - raw = (cnt < duty_shadow), unsigned.
  - Duty 0 gives raw always 0.
  - Duty 2^WIDTH-1 gives raw low only at cnt=max, i.e. 63/64. 100% duty is not supported.
- Dead-time FSM (registers tgt, dcnt), evaluated each edge while enabled:
  - If raw != tgt: tgt<=raw; both outputs <=0; dcnt<=DEAD_TIME. When DEAD_TIME==0, drive the new side directly instead.
  - Else if dcnt>1: dcnt<=dcnt-1; both outputs stay 0.
  - Else: dcnt<=0; PWM_Out<=tgt, PWM_Out_N<=~tgt.
  - A raw change during the dead interval restarts the interval toward the new target.
- Timing: if raw changes in cycle k, the old side falls at k+1 and the new side rises at k+1+DEAD_TIME.
- Invariant: PWM_Out && PWM_Out_N is never 1, including across reset, enable toggles and restart events.
- State names for coverage:
  - IDLE: disabled or reset.
  - DEAD: dcnt counting, both outputs low.
  - HIGH: PWM_Out=1.
  - LOW: PWM_Out_N=1.

Test Plan:
1. Reset:
   - Stimulus: reset=1 for 3 cycles, Enable=1, Duty_Input=20.
   - Required: PWM_Out=PWM_Out_N=Period_Start=0 throughout.
   - After release: Period_Start pulses on the first edge, then every 64 cycles.
2. Nominal waveform:
   - Stimulus: PRESCALE=1, DEAD_TIME=2, Duty_Input=16 held.
   - Required per 64-cycle period: PWM_Out high 14 cycles, PWM_Out_N high 46 cycles, two 2-cycle both-low gaps.
   - Required: PWM_Out rises exactly 3 cycles after Period_Start.
3. Boundary duties:
   - Duty 0: PWM_Out never asserts; PWM_Out_N stays high after the initial 2-cycle gap.
   - Duty 63: PWM_Out_N never asserts; PWM_Out low 3 cycles per period (DEAD_TIME+1 restart case).
4. Shadowing:
   - Stimulus: change Duty_Input 16->40 at cnt=5.
   - Required: current period keeps 14-cycle high; the next period (after Period_Start) gives 38-cycle high.
5. Prescaler and zero dead time:
   - Stimulus: PRESCALE=4, DEAD_TIME=0, duty 12.
   - Required: Period_Start spacing 256 cycles; PWM_Out high 48 cycles; PWM_Out_N high 208 cycles; no both-low cycle after the first period.
6. Enable drop mid-period:
   - Stimulus: Enable=0 at cnt=30 while PWM_Out=1.
   - Required: both outputs 0 next cycle.
   - On re-enable: Period_Start on the first edge, cnt restarts at 0, and the overlap assertion holds throughout.
